tiger_hazard_scoreboard: RTL

TIGER_HAZARD_SCOREBOARD -- requirements
Module: tiger_hazard_scoreboard

---
 rtl/tiger_hazard_scoreboard.sv | 136 +++++++++++++
 1 files changed

// File: rtl/tiger_hazard_scoreboard.sv
// tiger_hazard_scoreboard
//   Register-result scoreboard and pipeline stall/bubble controller for an
//   in-order pipeline. Each architectural register 1..31 has a countdown of
//   cycles until its pending result can be forwarded. Decode is held while a
//   source register is still pending, or while a destination register has an
//   older write that would complete after the new one (WAW).
//
// Parameters
//   NUM_STAGES : pipeline stage count (3..8); stage 0 = decode, 1 = execute
//   LAT_WIDTH  : width of the result-latency field
//
// Ports
//   clk, reset_n                  : clock, asynchronous active-low reset
//   issueValid                    : decode holds a valid instruction
//   issueWriteEn, issueWriteReg   : decode instruction's destination write
//   issueLatency                  : cycles until that result is forwardable
//   deRsNum/deRtNum, deNeedsRs/Rt : decode source operands
//   stageNeedStall[NUM_STAGES]    : external per-stage stall requests
//   exception                     : flush decode
//   stall[NUM_STAGES]             : per-stage hold
//   clear[NUM_STAGES]             : per-stage bubble insert
//   pendingMask[32]               : bit r set while register r is pending
//   hazardCycles, stallCycles     : saturating statistics counters, present
//                                   only when TIGER_HAZARD_STATS_EN is defined
module tiger_hazard_scoreboard #(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned LAT_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  issueValid,
  input  logic                  issueWriteEn,
  input  logic [4:0]            issueWriteReg,
  input  logic [LAT_WIDTH-1:0]  issueLatency,
  input  logic [4:0]            deRsNum,
  input  logic [4:0]            deRtNum,
  input  logic                  deNeedsRs,
  input  logic                  deNeedsRt,
  input  logic [NUM_STAGES-1:0] stageNeedStall,
  input  logic                  exception,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] clear,
  output logic [31:0]           pendingMask
`ifdef TIGER_HAZARD_STATS_EN
  ,
  output logic [31:0]           hazardCycles,
  output logic [31:0]           stallCycles
`endif
);

  // Entry 0 is held at zero so r0 reads never hazard.
  logic [LAT_WIDTH-1:0]  cnt_q [32];
  logic                  hazard;
  logic                  issue;
  logic [NUM_STAGES-1:0] need;

  always_comb begin
    hazard = issueValid &&
             ((deNeedsRs && (cnt_q[deRsNum] != '0)) ||
              (deNeedsRt && (cnt_q[deRtNum] != '0)) ||
              (issueWriteEn && (cnt_q[issueWriteReg] > issueLatency)));
  end

  always_comb begin
    need    = stageNeedStall;
    need[0] = stageNeedStall[0] | hazard;
  end

  // A stage holds if it or any later stage needs to hold.
  always_comb begin
    logic acc;
    acc   = 1'b0;
    stall = '0;
    for (int i = int'(NUM_STAGES) - 1; i >= 0; i--) begin
      acc      = acc | need[i];
      stall[i] = acc;
    end
  end

  // A bubble enters stage i when stage i-1 holds but stage i advances.
  always_comb begin
    clear    = '0;
    clear[0] = exception && !stall[0];
    for (int i = 1; i < int'(NUM_STAGES); i++) begin
      clear[i] = need[i-1] && !stall[i];
    end
  end

  always_comb begin
    issue = issueValid && !stall[0] && issueWriteEn &&
            (issueWriteReg != 5'd0) && (issueLatency != '0);
  end

  // Countdowns advance with the execute stage; a new load wins over a decrement.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (issue && (issueWriteReg == 5'(r))) begin
          cnt_q[r] <= issueLatency;
        end else if (!stall[1] && (cnt_q[r] != '0)) begin
          cnt_q[r] <= cnt_q[r] - LAT_WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    pendingMask = '0;
    for (int r = 1; r < 32; r++) begin
      pendingMask[r] = (cnt_q[r] != '0);
    end
  end

`ifdef TIGER_HAZARD_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hazardCycles <= '0;
      stallCycles  <= '0;
    end else begin
      if (hazard && (hazardCycles != '1)) begin
        hazardCycles <= hazardCycles + 32'd1;
      end
      if (stall[0] && (stallCycles != '1)) begin
        stallCycles <= stallCycles + 32'd1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
